// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared definitions for the RTC read-cycle sequencer: state encoding,
// default phase timing, bus width and the Moore output decode used by the
// top level (rtc_ciclo_lectura).
package rtc_pkg;

  localparam int ANCHO_BUS     = 8;
  localparam int T_DIR_DEF     = 10;
  localparam int T_ESP_DEF     = 5;
  localparam int T_LECT_DEF    = 10;
  localparam int ANCHO_CNT_DEF = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIR  = 3'd1,
    ESP1 = 3'd2,
    LECT = 3'd3,
    ESP2 = 3'd4,
    FIN  = 3'd5
  } estado_e;

  typedef struct packed {
    logic                 cs_n;
    logic                 ad_n;
    logic                 rd_n;
    logic                 wr_n;
    logic                 ad_oe;
    logic [ANCHO_BUS-1:0] ad_out;
    logic                 ocupado;
    logic                 listo;
  } salidas_t;

  // Bus pins as a function of the phase. The address stays driven through
  // ESP1 to give the RTC hold time after the AD_n/WR_n latch edge.
  function automatic salidas_t decodificar(estado_e estado, logic [ANCHO_BUS-1:0] addr);
    salidas_t s;
    s.cs_n    = 1'b1;
    s.ad_n    = 1'b1;
    s.rd_n    = 1'b1;
    s.wr_n    = 1'b1;
    s.ad_oe   = 1'b0;
    s.ad_out  = '0;
    s.ocupado = (estado != IDLE);
    s.listo   = (estado == FIN);
    case (estado)
      DIR: begin
        s.cs_n   = 1'b0;
        s.ad_n   = 1'b0;
        s.wr_n   = 1'b0;
        s.ad_oe  = 1'b1;
        s.ad_out = addr;
      end
      ESP1: begin
        s.cs_n   = 1'b0;
        s.ad_oe  = 1'b1;
        s.ad_out = addr;
      end
      LECT: begin
        s.cs_n = 1'b0;
        s.rd_n = 1'b0;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_ciclo_lectura_contador_fase.sv
// contador_fase
// Phase timer: counts 0..limite-1 inside one bus phase and flags the last
// cycle so the sequencer knows when to move on.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   clr_i       forces the count back to 0 at the next edge (phase change)
//   limite_i    phase length in cycles (>= 1)
//   cuenta_o    current position inside the phase
//   fin_fase_o  1 during the last cycle of the phase (cuenta == limite-1)
module contador_fase #(
  parameter int ANCHO_CNT = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic [ANCHO_CNT:0]   limite_i,
  output logic [ANCHO_CNT-1:0] cuenta_o,
  output logic                 fin_fase_o
);

  logic [ANCHO_CNT-1:0] cuenta_q;
  logic [ANCHO_CNT-1:0] cuenta_d;

  // The limit is one bit wider than the count so a phase of exactly
  // 2**ANCHO_CNT cycles is still representable.
  always_comb begin
    cuenta_d = clr_i ? '0 : cuenta_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta_o   = cuenta_q;
  assign fin_fase_o = ({1'b0, cuenta_q} == (limite_i - 1'b1));

endmodule

// File: rtl/rtc_ciclo_lectura.sv
// rtc_ciclo_lectura
// Intel-mode read cycle on the RTC multiplexed AD bus: address phase,
// hold/wait, RD_n strobe with data capture, recovery, one-cycle done pulse.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   inicio_i      start request, honoured only when idle
//   direccion_i   RTC register address, latched on an accepted start
//   dato_in_i     AD bus value coming back from the pad
//   cs_n_o, ad_n_o, rd_n_o, wr_n_o   active-low bus strobes
//   ad_out_o, ad_oe_o                AD bus drive value and pad enable
//   dato_leido_o  last captured read byte
//   ocupado_o     high whenever a cycle is in progress
//   listo_o       one-cycle completion pulse
module rtc_ciclo_lectura
  import rtc_pkg::*;
#(
  parameter int T_DIR     = T_DIR_DEF,
  parameter int T_ESP     = T_ESP_DEF,
  parameter int T_LECT    = T_LECT_DEF,
  parameter int ANCHO_CNT = ANCHO_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio_i,
  input  logic [ANCHO_BUS-1:0] direccion_i,
  input  logic [ANCHO_BUS-1:0] dato_in_i,
  output logic                 cs_n_o,
  output logic                 ad_n_o,
  output logic                 rd_n_o,
  output logic                 wr_n_o,
  output logic [ANCHO_BUS-1:0] ad_out_o,
  output logic                 ad_oe_o,
  output logic [ANCHO_BUS-1:0] dato_leido_o,
  output logic                 ocupado_o,
  output logic                 listo_o
);

  if (T_DIR < 1 || T_ESP < 1 || T_LECT < 1 ||
      (T_DIR - 1) >= (1 << ANCHO_CNT) ||
      (T_ESP - 1) >= (1 << ANCHO_CNT) ||
      (T_LECT - 1) >= (1 << ANCHO_CNT)) begin : g_param_err
    $error("rtc_ciclo_lectura: phase lengths must be >= 1 and fit ANCHO_CNT");
  end

  localparam logic [ANCHO_CNT:0]   LIM_DIR  = (ANCHO_CNT + 1)'(T_DIR);
  localparam logic [ANCHO_CNT:0]   LIM_ESP  = (ANCHO_CNT + 1)'(T_ESP);
  localparam logic [ANCHO_CNT:0]   LIM_LECT = (ANCHO_CNT + 1)'(T_LECT);
  localparam logic [ANCHO_CNT-1:0] ULT_LECT = ANCHO_CNT'(T_LECT - 1);

  estado_e              estado_q, estado_d;
  logic [ANCHO_BUS-1:0] addr_q, addr_d;
  logic [ANCHO_BUS-1:0] dato_q, dato_d;
  salidas_t             sal_q;
  logic [ANCHO_CNT:0]   limite;
  logic [ANCHO_CNT-1:0] cuenta;
  logic                 fin_fase;
  logic                 clr;

  // While idle the counter is held at 0, so every phase starts counting
  // from a clean zero the cycle after its entry edge.
  assign clr = (estado_d != estado_q) || (estado_q == IDLE);

  contador_fase #(
    .ANCHO_CNT (ANCHO_CNT)
  ) u_contador (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (clr),
    .limite_i   (limite),
    .cuenta_o   (cuenta),
    .fin_fase_o (fin_fase)
  );

  // Phase length seen by the counter; IDLE and FIN use 1 as a harmless value.
  always_comb begin
    limite = (ANCHO_CNT + 1)'(1);
    case (estado_q)
      DIR:     limite = LIM_DIR;
      ESP1:    limite = LIM_ESP;
      LECT:    limite = LIM_LECT;
      ESP2:    limite = LIM_ESP;
      default: limite = (ANCHO_CNT + 1)'(1);
    endcase
  end

  // Sequencing. The read byte is taken on the final LECT edge, when the
  // count reaches its last value and RD_n is still low.
  always_comb begin
    estado_d = estado_q;
    addr_d   = addr_q;
    dato_d   = dato_q;
    case (estado_q)
      IDLE: begin
        if (inicio_i) begin
          estado_d = DIR;
          addr_d   = direccion_i;
        end
      end
      DIR:  if (fin_fase) estado_d = ESP1;
      ESP1: if (fin_fase) estado_d = LECT;
      LECT: begin
        if (cuenta == ULT_LECT) begin
          dato_d = dato_in_i;
        end
        if (fin_fase) estado_d = ESP2;
      end
      ESP2: if (fin_fase) estado_d = FIN;
      FIN:  estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, which equals a Moore
  // decode of the current state but with every pin coming straight from a
  // flop, keeping the strobes free of decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      addr_q   <= '0;
      dato_q   <= '0;
      sal_q    <= decodificar(IDLE, '0);
    end else begin
      estado_q <= estado_d;
      addr_q   <= addr_d;
      dato_q   <= dato_d;
      sal_q    <= decodificar(estado_d, addr_d);
    end
  end

  assign cs_n_o       = sal_q.cs_n;
  assign ad_n_o       = sal_q.ad_n;
  assign rd_n_o       = sal_q.rd_n;
  assign wr_n_o       = sal_q.wr_n;
  assign ad_oe_o      = sal_q.ad_oe;
  assign ad_out_o     = sal_q.ad_out;
  assign ocupado_o    = sal_q.ocupado;
  assign listo_o      = sal_q.listo;
  assign dato_leido_o = dato_q;

endmodule

// File: tb/tb_rtc_ciclo_lectura.sv
// tb_rtc_ciclo_lectura
// Two sequencers share one set of inputs: one with default timing and one
// with every phase one cycle long. A timeline model (cycles elapsed since the
// accepted start) predicts every pin, and a few directed runs pin literal
// latencies, captured bytes and reset behaviour.
module tb_rtc_ciclo_lectura;

  localparam int TD[2] = '{10, 1};
  localparam int TE[2] = '{5, 1};
  localparam int TL[2] = '{10, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio;
  logic [7:0] direccion;
  logic [7:0] datoIn;

  logic       csN[2], adN[2], rdN[2], wrN[2], adOe[2], ocupado[2], listo[2];
  logic [7:0] adOut[2], datoLeido[2];

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  // Model: k = 0 when idle, otherwise k cycles since the accepting edge
  // (k = 1 in the cycle right after it).
  int         k[2]     = '{0, 0};
  logic [7:0] mAddr[2] = '{8'h00, 8'h00};
  logic [7:0] mDato[2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  rtc_ciclo_lectura u_dut0 (
    .clk (clk), .reset (reset), .inicio_i (inicio), .direccion_i (direccion),
    .dato_in_i (datoIn), .cs_n_o (csN[0]), .ad_n_o (adN[0]), .rd_n_o (rdN[0]),
    .wr_n_o (wrN[0]), .ad_out_o (adOut[0]), .ad_oe_o (adOe[0]),
    .dato_leido_o (datoLeido[0]), .ocupado_o (ocupado[0]), .listo_o (listo[0])
  );

  rtc_ciclo_lectura #(
    .T_DIR (1), .T_ESP (1), .T_LECT (1), .ANCHO_CNT (5)
  ) u_dut1 (
    .clk (clk), .reset (reset), .inicio_i (inicio), .direccion_i (direccion),
    .dato_in_i (datoIn), .cs_n_o (csN[1]), .ad_n_o (adN[1]), .rd_n_o (rdN[1]),
    .wr_n_o (wrN[1]), .ad_out_o (adOut[1]), .ad_oe_o (adOe[1]),
    .dato_leido_o (datoLeido[1]), .ocupado_o (ocupado[1]), .listo_o (listo[1])
  );

  // Timeline model advanced on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        k[i]     = 0;
        mDato[i] = 8'h00;
      end else if (k[i] == 0) begin
        if (inicio) begin
          k[i]     = 1;
          mAddr[i] = direccion;
        end
      end else begin
        if (k[i] == TD[i] + TE[i] + TL[i]) mDato[i] = datoIn;
        if (k[i] == TD[i] + 2 * TE[i] + TL[i] + 1) k[i] = 0;
        else k[i] = k[i] + 1;
      end
    end
  end

  task automatic checkOutput(string name, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] actual=%0h expected=%0h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every pin against the timeline model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 2; i++) begin
        bit dir, esp1, lect, fin;
        int kk;
        kk   = k[i];
        dir  = (kk >= 1) && (kk <= TD[i]);
        esp1 = (kk > TD[i]) && (kk <= TD[i] + TE[i]);
        lect = (kk > TD[i] + TE[i]) && (kk <= TD[i] + TE[i] + TL[i]);
        fin  = (kk == TD[i] + 2 * TE[i] + TL[i] + 1);
        checkOutput("cs_n", i, int'(csN[i]), int'(!(dir || esp1 || lect)));
        checkOutput("ad_n", i, int'(adN[i]), int'(!dir));
        checkOutput("wr_n", i, int'(wrN[i]), int'(!dir));
        checkOutput("rd_n", i, int'(rdN[i]), int'(!lect));
        checkOutput("ad_oe", i, int'(adOe[i]), int'(dir || esp1));
        checkOutput("ad_out", i, int'(adOut[i]), (dir || esp1) ? int'(mAddr[i]) : 0);
        checkOutput("dato_leido", i, int'(datoLeido[i]), int'(mDato[i]));
        checkOutput("ocupado", i, int'(ocupado[i]), int'(kk != 0));
        checkOutput("listo", i, int'(listo[i]), int'(fin));
      end
    end
  end

  // Presents a one-cycle start request; returns just after the negedge that
  // follows the accepting edge, i.e. in the k = 1 cycle.
  task automatic applyStimulus(input logic [7:0] addr);
    @(negedge clk); #1;
    inicio    = 1'b1;
    direccion = addr;
    @(negedge clk); #1;
    inicio    = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int lat0, lat1, rdLow, dirLow, pulses;

    reset     = 1'b1;
    inicio    = 1'b0;
    direccion = 8'h00;
    datoIn    = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_cs_n", 0, int'(csN[0]), 1);
    checkOutput("reset_ad_oe", 0, int'(adOe[0]), 0);
    checkOutput("reset_dato", 0, int'(datoLeido[0]), 0);
    #1 reset = 1'b0;
    checkEn = 1'b1;
    idleCycles(2);

    // Basic read plus an address change during DIR.
    datoIn = 8'hA5;
    applyStimulus(8'h23);
    lat0 = -1; lat1 = -1; rdLow = 0; dirLow = 0;
    for (int c = 1; c <= 40; c++) begin
      if (listo[0] && lat0 < 0) lat0 = c - 1;
      if (listo[1] && lat1 < 0) lat1 = c - 1;
      if (!rdN[0]) rdLow++;
      if (!adN[0]) dirLow++;
      if (c == 3) direccion = 8'h7F;
      if (c == 13) checkOutput("ad_out_esp1", 0, int'(adOut[0]), 8'h23);
      idleCycles(1);
    end
    checkOutput("latency_default", 0, lat0, 30);
    checkOutput("latency_t1", 1, lat1, 4);
    checkOutput("rd_low_cycles", 0, rdLow, 10);
    checkOutput("dir_cycles", 0, dirLow, 10);
    checkOutput("dato_a5", 0, int'(datoLeido[0]), 8'hA5);

    // Reset in the middle of LECT, count 4 (k = 20).
    applyStimulus(8'h31);
    idleCycles(19);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_rd_n", 0, int'(rdN[0]), 1);
    checkOutput("midreset_ad_oe", 0, int'(adOe[0]), 0);
    checkOutput("midreset_dato", 0, int'(datoLeido[0]), 0);
    checkOutput("midreset_ocupado", 0, int'(ocupado[0]), 0);
    #1 reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (listo[0]) pulses++;
      idleCycles(1);
    end
    checkOutput("midreset_no_listo", 0, pulses, 0);

    // Data changing right before and right after the capture edge.
    datoIn = 8'h11;
    applyStimulus(8'h45);
    idleCycles(24);
    datoIn = 8'h5A;
    idleCycles(1);
    datoIn = 8'h33;
    idleCycles(10);
    checkOutput("dato_5a", 0, int'(datoLeido[0]), 8'h5A);
    idleCycles(5);

    // inicio held for 64 edges: two back-to-back reads on the default unit.
    @(negedge clk); #1;
    inicio    = 1'b1;
    direccion = 8'h0C;
    pulses    = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk); #1;
      if (listo[0]) pulses++;
    end
    inicio = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (listo[0]) pulses++;
      idleCycles(1);
    end
    checkOutput("backtoback_listo", 0, pulses, 2);

    // Random traffic, all checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      inicio    = ($urandom_range(7) == 0);
      direccion = 8'($urandom);
      datoIn    = 8'($urandom);
      reset     = ($urandom_range(299) == 0);
      idleCycles(1);
    end
    reset  = 1'b0;
    inicio = 1'b0;
    idleCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
